// File: rtl/dzcpu_useq_pkg.sv
// Shared constants for the dzcpu microcode sequencer: uop field layout, flow codes, FSM states.
package dzcpu_useq_pkg;

  localparam int FLOW_W = 3;
  localparam int OP_W   = 4;

  localparam logic [FLOW_W-1:0] FLOW_OP        = 3'd0;
  localparam logic [FLOW_W-1:0] FLOW_INC       = 3'd1;
  localparam logic [FLOW_W-1:0] FLOW_EOF       = 3'd2;
  localparam logic [FLOW_W-1:0] FLOW_INC_EOF   = 3'd3;
  localparam logic [FLOW_W-1:0] FLOW_INC_EOF_Z = 3'd4;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_JCB = 4'hA;

  typedef enum logic [1:0] {
    S_FETCH       = 2'd0,
    S_DISPATCH    = 2'd1,
    S_EXEC        = 2'd2,
    S_CB_DISPATCH = 2'd3
  } useq_state_e;

  // Builds a 12-bit uop with the flow and op fields in place and zeroed payload bits.
  function automatic logic [11:0] mk_uop(input logic [FLOW_W-1:0] flow, input logic [OP_W-1:0] op);
    return {flow, op, 5'b0};
  endfunction

endpackage

// File: rtl/dzcpu_uflow_decode.sv
// Combinational decode of a uop's flow/op fields into sequencing controls.
module dzcpu_uflow_decode
  import dzcpu_useq_pkg::*;
(
  input  logic [FLOW_W-1:0] i_flow,
  input  logic [OP_W-1:0]   i_op,
  input  logic              i_flag_z,
  output logic              o_adv,
  output logic              o_pcinc,
  output logic              o_eof,
  output logic              o_jcb
);

  always_comb begin
    o_adv   = 1'b0;
    o_pcinc = 1'b0;
    o_eof   = 1'b0;
    o_jcb   = (i_op == OP_JCB);
    case (i_flow)
      FLOW_INC: begin
        o_pcinc = 1'b1;
        o_adv   = 1'b1;
      end
      FLOW_EOF: begin
        o_eof = 1'b1;
      end
      FLOW_INC_EOF: begin
        o_pcinc = 1'b1;
        o_eof   = 1'b1;
      end
      FLOW_INC_EOF_Z: begin
        o_pcinc = 1'b1;
        o_eof   = i_flag_z;
        o_adv   = ~i_flag_z;
      end
      // FLOW_OP and unassigned codes simply advance
      default: begin
        o_adv = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: opcode fetch, LUT dispatch (normal and CB), micro-PC stepping.
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter int                   UADDR_W   = 8,
  parameter int                   UOP_W     = 12,
  parameter logic [UADDR_W-1:0]   IRQ_UADDR = 8'hF0
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic [7:0]         iMop,
  input  logic               iMemReady,
  input  logic               iStall,
  input  logic               iFlagZ,
  input  logic               iIrqReq,
  input  logic [UOP_W-1:0]   iUop,
  input  logic [UADDR_W-1:0] iFlowIdx,
  input  logic [UADDR_W-1:0] iCbFlowIdx,
  output logic [7:0]         oMop,
  output logic [UADDR_W-1:0] oUopAddr,
  output logic               oUopValid,
  output logic               oPcInc,
  output logic               oFetch,
  output logic               oCbMode,
  output logic               oIrqAck,
  output logic               oIllegal
);

  useq_state_e        r_state, r_state_next;
  logic [UADDR_W-1:0] r_upc, r_upc_next;
  logic [7:0]         r_mop, r_mop_next;
  logic               r_cb_mode, r_cb_mode_next;

  logic [FLOW_W-1:0]  w_flow;
  logic [OP_W-1:0]    w_op;
  logic               w_adv, w_pcinc, w_eof, w_jcb;
  logic               w_upc_last;
  logic               w_exec_go;
  logic               w_uop_valid, w_pc_inc, w_fetch, w_irq_ack, w_illegal;
  logic               w_unused_payload;

  assign w_flow     = iUop[UOP_W-1 -: FLOW_W];
  assign w_op       = iUop[UOP_W-4 -: OP_W];
  assign w_upc_last = &r_upc;
  // Payload bits belong to the datapath; the sequencer only looks at flow/op.
  assign w_unused_payload = &{1'b0, iUop[UOP_W-FLOW_W-OP_W-1:0]};

  dzcpu_uflow_decode u_decode (
    .i_flow   (w_flow),
    .i_op     (w_op),
    .i_flag_z (iFlagZ),
    .o_adv    (w_adv),
    .o_pcinc  (w_pcinc),
    .o_eof    (w_eof),
    .o_jcb    (w_jcb)
  );

  // A jcb without the CB byte available behaves exactly like a stall.
  assign w_exec_go = ~iStall & ~(w_jcb & ~iMemReady);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state   <= S_FETCH;
      r_upc     <= '0;
      r_mop     <= 8'h00;
      r_cb_mode <= 1'b0;
    end else begin
      r_state   <= r_state_next;
      r_upc     <= r_upc_next;
      r_mop     <= r_mop_next;
      r_cb_mode <= r_cb_mode_next;
    end
  end

  always_comb begin
    r_state_next   = r_state;
    r_upc_next     = r_upc;
    r_mop_next     = r_mop;
    r_cb_mode_next = r_cb_mode;
    w_uop_valid    = 1'b0;
    w_pc_inc       = 1'b0;
    w_fetch        = 1'b0;
    w_irq_ack      = 1'b0;
    w_illegal      = 1'b0;

    case (r_state)
      S_FETCH: begin
        r_cb_mode_next = 1'b0;
        if (iIrqReq) begin
          w_irq_ack    = 1'b1;
          r_upc_next   = IRQ_UADDR;
          r_state_next = S_EXEC;
        end else begin
          w_fetch = 1'b1;
          if (iMemReady) begin
            r_mop_next   = iMop;
            r_state_next = S_DISPATCH;
          end
        end
      end

      S_DISPATCH: begin
        r_upc_next   = iFlowIdx;
        r_state_next = S_EXEC;
      end

      S_EXEC: begin
        if (w_exec_go) begin
          w_uop_valid = 1'b1;
          w_pc_inc    = w_pcinc;
          if (w_jcb) begin
            r_mop_next     = iMop;
            r_cb_mode_next = 1'b1;
            r_state_next   = S_CB_DISPATCH;
          end else if (w_eof) begin
            r_cb_mode_next = 1'b0;
            r_state_next   = S_FETCH;
          end else if (w_adv) begin
            if (w_upc_last) begin
              w_illegal      = 1'b1;
              r_upc_next     = '0;
              r_cb_mode_next = 1'b0;
              r_state_next   = S_FETCH;
            end else begin
              r_upc_next = r_upc + 1'b1;
            end
          end
        end
      end

      S_CB_DISPATCH: begin
        if (iCbFlowIdx != '0) begin
          r_upc_next   = iCbFlowIdx;
          r_state_next = S_EXEC;
        end else begin
          w_illegal      = 1'b1;
          r_cb_mode_next = 1'b0;
          r_state_next   = S_FETCH;
        end
      end

      default: begin
        r_state_next = S_FETCH;
      end
    endcase
  end

  // Strobes drop the instant reset asserts, not at the next edge.
  assign oUopValid = w_uop_valid & ~iReset;
  assign oPcInc    = w_pc_inc    & ~iReset;
  assign oFetch    = w_fetch     & ~iReset;
  assign oIrqAck   = w_irq_ack   & ~iReset;
  assign oIllegal  = w_illegal   & ~iReset;

  assign oMop     = r_mop;
  assign oUopAddr = r_upc;
  assign oCbMode  = r_cb_mode;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Directed bench for dzcpu_useq with stub ROM/LUT models programmed per scenario.
module tb_dzcpu_useq;
  import dzcpu_useq_pkg::*;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [7:0]  iMop = 8'h00;
  logic        iMemReady = 1'b0;
  logic        iStall = 1'b0;
  logic        iFlagZ = 1'b0;
  logic        iIrqReq = 1'b0;
  logic [11:0] iUop;
  logic [7:0]  iFlowIdx;
  logic [7:0]  iCbFlowIdx;
  logic [7:0]  oMop;
  logic [7:0]  oUopAddr;
  logic        oUopValid, oPcInc, oFetch, oCbMode, oIrqAck, oIllegal;

  logic [11:0] rom   [0:255];
  logic [7:0]  lut   [0:255];
  logic [7:0]  cblut [0:255];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 iClock = ~iClock;

  assign iUop       = rom[oUopAddr];
  assign iFlowIdx   = lut[oMop];
  assign iCbFlowIdx = cblut[oMop];

  dzcpu_useq #(.UADDR_W(8), .UOP_W(12), .IRQ_UADDR(8'hF0)) dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iMop       (iMop),
    .iMemReady  (iMemReady),
    .iStall     (iStall),
    .iFlagZ     (iFlagZ),
    .iIrqReq    (iIrqReq),
    .iUop       (iUop),
    .iFlowIdx   (iFlowIdx),
    .iCbFlowIdx (iCbFlowIdx),
    .oMop       (oMop),
    .oUopAddr   (oUopAddr),
    .oUopValid  (oUopValid),
    .oPcInc     (oPcInc),
    .oFetch     (oFetch),
    .oCbMode    (oCbMode),
    .oIrqAck    (oIrqAck),
    .oIllegal   (oIllegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge iClock);
    @(negedge iClock);
  endtask

  // From FETCH: present opcode, pass DISPATCH, return at negedge of first EXEC cycle.
  task automatic start(input logic [7:0] op);
    $display("txn: fetch opcode %02h", op);
    iMop      = op;
    iMemReady = 1'b1;
    nxt();
    iMemReady = 1'b0;
    nxt();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]   = mk_uop(FLOW_OP, OP_NOP);
      lut[i]   = 8'h00;
      cblut[i] = 8'h00;
    end
    lut[8'h31] = 8'd1;
    rom[1] = mk_uop(FLOW_INC, OP_NOP);
    rom[2] = mk_uop(FLOW_INC, OP_NOP);
    rom[3] = mk_uop(FLOW_OP, OP_NOP);
    rom[4] = mk_uop(FLOW_INC_EOF, OP_NOP);
    lut[8'h42] = 8'd19;
    rom[19] = mk_uop(FLOW_INC_EOF_Z, OP_NOP);
    rom[20] = mk_uop(FLOW_OP, OP_NOP);
    rom[21] = mk_uop(FLOW_OP, OP_NOP);
    rom[22] = mk_uop(FLOW_EOF, OP_NOP);
    lut[8'hCB] = 8'd15;
    rom[15] = mk_uop(FLOW_INC, OP_JCB);
    cblut[8'h7C] = 8'd16;
    rom[16] = mk_uop(FLOW_INC_EOF, OP_NOP);
    rom[8'hF0] = mk_uop(FLOW_EOF, OP_NOP);
    lut[8'h55] = 8'hFE;

    // Reset state
    repeat (2) @(negedge iClock);
    #1;
    chk("reset_upc",   32'(oUopAddr),  32'h0);
    chk("reset_mop",   32'(oMop),      32'h0);
    chk("reset_cb",    32'(oCbMode),   32'h0);
    chk("reset_fetch", 32'(oFetch),    32'h0);
    chk("reset_valid", 32'(oUopValid), 32'h0);
    iReset = 1'b0;
    #1;
    chk("post_reset_fetch", 32'(oFetch), 32'h1);

    // Scenario 1: opcode 31 -> uPC 1..4
    $display("txn: fetch opcode 31 (linear flow)");
    iMop = 8'h31; iMemReady = 1'b1; #1;
    chk("t1_fetch", 32'(oFetch), 32'h1);
    nxt(); iMemReady = 1'b0; #1;
    chk("t1_disp_mop",   32'(oMop),      32'h31);
    chk("t1_disp_valid", 32'(oUopValid), 32'h0);
    nxt(); #1;
    chk("t1_upc1", 32'(oUopAddr), 32'h1);
    chk("t1_inc1", 32'(oPcInc),   32'h1);
    nxt(); #1;
    chk("t1_upc2", 32'(oUopAddr), 32'h2);
    chk("t1_inc2", 32'(oPcInc),   32'h1);
    nxt(); #1;
    chk("t1_upc3",   32'(oUopAddr),  32'h3);
    chk("t1_inc3",   32'(oPcInc),    32'h0);
    chk("t1_valid3", 32'(oUopValid), 32'h1);
    nxt(); #1;
    chk("t1_upc4", 32'(oUopAddr), 32'h4);
    chk("t1_inc4", 32'(oPcInc),   32'h1);
    nxt(); #1;
    chk("t1_refetch", 32'(oFetch),    32'h1);
    chk("t1_novalid", 32'(oUopValid), 32'h0);

    // Scenario 5 + 6: stall at uPC 2, then IRQ raised during eof
    start(8'h31); #1;
    chk("t5_upc1", 32'(oUopAddr), 32'h1);
    nxt(); iStall = 1'b1; #1;
    chk("t5_stall_valid", 32'(oUopValid), 32'h0);
    chk("t5_stall_inc",   32'(oPcInc),    32'h0);
    nxt(); #1;
    chk("t5_stall_upc_b", 32'(oUopAddr), 32'h2);
    nxt(); #1;
    chk("t5_stall_upc_c", 32'(oUopAddr), 32'h2);
    nxt(); iStall = 1'b0; #1;
    chk("t5_resume_upc",   32'(oUopAddr),  32'h2);
    chk("t5_resume_valid", 32'(oUopValid), 32'h1);
    chk("t5_resume_inc",   32'(oPcInc),    32'h1);
    nxt(); #1;
    chk("t5_upc3", 32'(oUopAddr), 32'h3);
    nxt(); iIrqReq = 1'b1; #1;
    chk("t6_eof_valid", 32'(oUopValid), 32'h1);
    chk("t6_eof_noack", 32'(oIrqAck),   32'h0);
    nxt(); #1;
    chk("t6_ack",     32'(oIrqAck), 32'h1);
    chk("t6_nofetch", 32'(oFetch),  32'h0);
    nxt(); iIrqReq = 1'b0; #1;
    chk("t6_irq_upc",   32'(oUopAddr),  32'hF0);
    chk("t6_ack_pulse", 32'(oIrqAck),   32'h0);
    chk("t6_irq_valid", 32'(oUopValid), 32'h1);
    nxt(); #1;
    chk("t6_refetch", 32'(oFetch), 32'h1);

    // Scenario 2: inc_eof_z with Z=1 then Z=0
    iFlagZ = 1'b1;
    start(8'h42); #1;
    chk("t2z_upc19", 32'(oUopAddr), 32'd19);
    chk("t2z_inc",   32'(oPcInc),   32'h1);
    nxt(); #1;
    chk("t2z_fetch", 32'(oFetch), 32'h1);
    iFlagZ = 1'b0;
    start(8'h42); #1;
    chk("t2n_inc19", 32'(oPcInc), 32'h1);
    nxt(); #1;
    chk("t2n_upc20", 32'(oUopAddr), 32'd20);
    chk("t2n_inc20", 32'(oPcInc),   32'h0);
    nxt(); #1;
    chk("t2n_upc21", 32'(oUopAddr), 32'd21);
    nxt(); #1;
    chk("t2n_upc22", 32'(oUopAddr),  32'd22);
    chk("t2n_val22", 32'(oUopValid), 32'h1);
    nxt(); #1;
    chk("t2n_fetch", 32'(oFetch), 32'h1);

    // Scenario 3: CB prefix, jcb waits for memory first
    start(8'hCB);
    iMop = 8'h7C; #1;
    chk("t3_jcb_wait_valid", 32'(oUopValid), 32'h0);
    nxt(); #1;
    chk("t3_jcb_wait_upc", 32'(oUopAddr), 32'd15);
    iMemReady = 1'b1; #1;
    chk("t3_jcb_inc",   32'(oPcInc),    32'h1);
    chk("t3_jcb_valid", 32'(oUopValid), 32'h1);
    chk("t3_jcb_cb0",   32'(oCbMode),   32'h0);
    nxt(); iMemReady = 1'b0; #1;
    chk("t3_cbd_cb",      32'(oCbMode),   32'h1);
    chk("t3_cbd_mop",     32'(oMop),      32'h7C);
    chk("t3_cbd_valid",   32'(oUopValid), 32'h0);
    chk("t3_cbd_illegal", 32'(oIllegal),  32'h0);
    nxt(); #1;
    chk("t3_upc16", 32'(oUopAddr), 32'd16);
    chk("t3_cb16",  32'(oCbMode),  32'h1);
    chk("t3_inc16", 32'(oPcInc),   32'h1);
    nxt(); #1;
    chk("t3_fetch",    32'(oFetch),  32'h1);
    chk("t3_cb_clear", 32'(oCbMode), 32'h0);

    // Scenario 4: unmapped CB opcode
    start(8'hCB);
    iMop = 8'h7D; iMemReady = 1'b1; #1;
    nxt(); iMemReady = 1'b0; #1;
    chk("t4_illegal", 32'(oIllegal), 32'h1);
    chk("t4_cb_set",  32'(oCbMode),  32'h1);
    nxt(); #1;
    chk("t4_illegal_pulse", 32'(oIllegal), 32'h0);
    chk("t4_fetch",         32'(oFetch),   32'h1);
    chk("t4_cb_clear",      32'(oCbMode),  32'h0);

    // Micro-PC overflow from all-ones
    start(8'h55); #1;
    chk("ovf_upc_fe", 32'(oUopAddr), 32'hFE);
    chk("ovf_no_ill", 32'(oIllegal), 32'h0);
    nxt(); #1;
    chk("ovf_upc_ff",  32'(oUopAddr),  32'hFF);
    chk("ovf_illegal", 32'(oIllegal),  32'h1);
    chk("ovf_valid",   32'(oUopValid), 32'h1);
    nxt(); #1;
    chk("ovf_upc_wrap", 32'(oUopAddr), 32'h0);
    chk("ovf_fetch",    32'(oFetch),   32'h1);

    // Asynchronous reset mid-flow
    start(8'h31);
    nxt();
    iReset = 1'b1; #1;
    chk("arst_upc",   32'(oUopAddr),  32'h0);
    chk("arst_valid", 32'(oUopValid), 32'h0);
    chk("arst_inc",   32'(oPcInc),    32'h0);
    chk("arst_mop",   32'(oMop),      32'h0);
    nxt();
    iReset = 1'b0; #1;
    chk("arst_fetch", 32'(oFetch), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
